// File: rtl/key_cmd_encoder.sv
`default_nettype none
// ==========================================================================
// key_cmd_encoder : sync + debounce four push-buttons into one-shot commands
// Revision 1.0
// ==========================================================================
module key_cmd_encoder #(
  parameter int DB_CYCLES = 500000,
  parameter int W         = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  input  logic [3:0]   key_n,
  input  logic [W-1:0] sw,
  input  logic         cmd_ready,
  output logic         cmd_valid,
  output logic [2:0]   cmd_code,
  output logic [W-1:0] cmd_data,
  output logic         overrun,
  output logic [3:0]   key_state
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [3:0]   key_s1;
  logic [3:0]   key_s2;
  logic [W-1:0] sw_s1;
  logic [W-1:0] sw_s2;
  logic [3:0]   press;

  // Key flops reset to 1 so that a reset never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_debounce
    logic [CW-1:0] cnt;
    logic          stable;
    logic          differ;

    assign differ = (~key_s2[k]) != stable;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign press[k]     = differ && (cnt == CNT_LAST) && !stable;
    assign key_state[k] = stable;
  end

  logic [2:0] win_code;
  logic       any_press;
  logic       multi_press;
  logic       can_load;
  logic       load;
  logic       drop;

  // Descending scan so the lowest pressed index is written last and wins.
  always_comb begin
    win_code = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) win_code = 3'(i + 1);
    end
  end

  assign any_press   = |press;
  assign multi_press = (press & (press - 4'd1)) != 4'd0;
  assign can_load    = !cmd_valid || cmd_ready;
  assign load        = any_press && can_load;
  assign drop        = (any_press && !can_load) || multi_press;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      cmd_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        cmd_valid <= 1'b1;
        cmd_code  <= win_code;
        cmd_data  <= sw_s2;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        cmd_code  <= 3'd0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_encoder.sv
`default_nettype none
// ==========================================================================
// tb_key_cmd_encoder : directed + random bench against a behavioural model
// Revision 1.0
// ==========================================================================
module tb_key_cmd_encoder;

  localparam int DB = 4;
  localparam int W  = 8;

  logic         CLOCK_50 = 1'b0;
  logic         reset_n  = 1'b0;
  logic [3:0]   key_n    = 4'hF;
  logic [W-1:0] sw       = '0;
  logic         cmd_ready = 1'b0;
  logic         cmd_valid;
  logic [2:0]   cmd_code;
  logic [W-1:0] cmd_data;
  logic         overrun;
  logic [3:0]   key_state;

  key_cmd_encoder #(.DB_CYCLES(DB), .W(W)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .key_n     (key_n),
    .sw        (sw),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_data  (cmd_data),
    .overrun   (overrun),
    .key_state (key_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;
  int vcount = 0;

  // Reference model: inputs seen two edges late, a key changes state after
  // DB consecutive edges of disagreeing input, one-entry command slot.
  logic [3:0]   m_kpipe [2];
  logic [W-1:0] m_swpipe [2];
  int           m_run [4];
  logic [3:0]   m_state;
  logic         m_valid;
  logic [2:0]   m_code;
  logic [W-1:0] m_data;
  logic         m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kpipe[0] = 4'hF; m_kpipe[1] = 4'hF;
    m_swpipe[0] = '0;  m_swpipe[1] = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    m_state = 4'h0;
    m_valid = 1'b0;
    m_code  = 3'd0;
    m_data  = '0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step();
    int events[$];
    logic [3:0] lvl;
    lvl = ~m_kpipe[1];
    for (int k = 0; k < 4; k++) begin
      if (lvl[k] != m_state[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_state[k] = lvl[k];
          m_run[k]   = 0;
          if (lvl[k]) events.push_back(k);
        end
      end else begin
        m_run[k] = 0;
      end
    end
    if (events.size() > 0) begin
      if (events.size() > 1) m_ovr = 1'b1;
      if (!m_valid || cmd_ready) begin
        m_valid = 1'b1;
        m_code  = 3'(events[0] + 1);
        m_data  = m_swpipe[1];
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && cmd_ready) begin
      m_valid = 1'b0;
      m_code  = 3'd0;
    end
    m_kpipe[1]  = m_kpipe[0];  m_kpipe[0]  = key_n;
    m_swpipe[1] = m_swpipe[0]; m_swpipe[0] = sw;
  endtask

  task automatic compare_all();
    check_eq("valid",     cmd_valid, m_valid);
    check_eq("code",      cmd_code,  m_code);
    check_eq("data",      cmd_data,  m_data);
    check_eq("overrun",   overrun,   m_ovr);
    check_eq("key_state", key_state, m_state);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    compare_all();
    if (cmd_valid) vcount++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Entered just after a falling edge; reset lands mid-cycle.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_code",  cmd_code,  0);
    check_eq("rst_data",  cmd_data,  0);
    check_eq("rst_ovr",   overrun,   0);
    check_eq("rst_state", key_state, 0);
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  int rem [4];

  initial begin
    model_reset();
    @(negedge CLOCK_50);
    do_reset();

    // Clean single press, ready held high
    sw = 8'h5A; cmd_ready = 1'b1; key_n = 4'hF;
    ticks(3);
    key_n[0] = 1'b0;
    ticks(5);
    check_eq("t1_early", cmd_valid, 0);
    tick();
    check_eq("t1_valid", cmd_valid, 1);
    check_eq("t1_code",  cmd_code,  1);
    check_eq("t1_data",  cmd_data,  8'h5A);
    check_eq("t1_ovr",   overrun,   0);
    tick();
    check_eq("t1_once",  cmd_valid, 0);
    key_n = 4'hF; vcount = 0;
    ticks(10);
    check_eq("t1_release", vcount, 0);

    // Bounce shorter than qualification
    vcount = 0;
    key_n[1] = 1'b0; ticks(3);
    key_n[1] = 1'b1; ticks(1);
    key_n[1] = 1'b0; ticks(3);
    key_n[1] = 1'b1; ticks(4);
    check_eq("t2_bounce_cmds", vcount, 0);
    check_eq("t2_state1", key_state[1], 0);
    key_n[1] = 1'b0;
    ticks(5);
    check_eq("t2_early", cmd_valid, 0);
    tick();
    check_eq("t2_valid", cmd_valid, 1);
    check_eq("t2_code",  cmd_code,  2);
    key_n = 4'hF;
    ticks(10);

    // Blocked consumer drops the second press
    do_reset();
    cmd_ready = 1'b0; sw = 8'h11; key_n = 4'b1011;
    ticks(6);
    check_eq("t3_valid", cmd_valid, 1);
    check_eq("t3_code",  cmd_code,  3);
    sw = 8'h22; key_n = 4'b0011;
    ticks(8);
    check_eq("t3_hold_code", cmd_code, 3);
    check_eq("t3_hold_data", cmd_data, 8'h11);
    check_eq("t3_ovr",       overrun,  1);
    cmd_ready = 1'b1;
    tick();
    check_eq("t3_consumed", cmd_valid, 0);
    key_n = 4'hF;
    ticks(8);

    // Simultaneous presses: lowest index wins
    do_reset();
    cmd_ready = 1'b1; key_n = 4'b1001; vcount = 0;
    ticks(6);
    check_eq("t4_code", cmd_code, 2);
    check_eq("t4_ovr",  overrun,  1);
    key_n = 4'hF;
    ticks(10);
    check_eq("t4_single", vcount, 1);

    // Accept-and-reload on the same edge
    do_reset();
    cmd_ready = 1'b0; key_n = 4'b1110;
    ticks(6);
    check_eq("t5_code1", cmd_code, 1);
    key_n = 4'b0110;
    ticks(5);
    cmd_ready = 1'b1;
    tick();
    check_eq("t5_valid", cmd_valid, 1);
    check_eq("t5_code4", cmd_code,  4);
    check_eq("t5_ovr",   overrun,   0);
    tick();
    check_eq("t5_drain", cmd_valid, 0);
    key_n = 4'hF;
    ticks(8);

    // Async reset mid-debounce with a pending command, key held through it
    do_reset();
    cmd_ready = 1'b0; key_n = 4'b1101;
    ticks(6);
    check_eq("t6_pending", cmd_code, 2);
    key_n = 4'b1110;
    ticks(4);
    do_reset();
    ticks(DB);
    check_eq("t6_early", cmd_valid, 0);
    ticks(2);
    check_eq("t6_valid", cmd_valid, 1);
    check_eq("t6_code",  cmd_code,  1);
    check_eq("t6_ovr",   overrun,   0);
    cmd_ready = 1'b1;
    tick();
    check_eq("t6_consumed", cmd_valid, 0);
    ticks(10);
    key_n = 4'hF;
    ticks(8);

    // Random bouncing keys, random consumer, occasional async reset
    do_reset();
    for (int k = 0; k < 4; k++) rem[k] = $urandom_range(1, 10);
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          rem[k]   = $urandom_range(1, 10);
        end else begin
          rem[k]--;
        end
      end
      sw        = W'($urandom);
      cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
